// File: rtl/cache_pkg.sv
// Shared types, sizes and address helpers for the direct-mapped cache refill controller.
package cache_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SET_BITS = 3;
    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int TAG_W    = 27;

    typedef struct packed {
        logic              v;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        MEM_WR,
        RESP
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [SET_BITS-1:0] idx;
    } waddr_t;

    // Takes the word address (byte offset already dropped) and splits it into tag and index.
    function automatic waddr_t split_addr(input logic [ADDR_W-3:0] waddr);
        return waddr_t'(waddr);
    endfunction
endpackage

// File: rtl/cache_refill_if.sv
// CPU request/response and data-memory handshake signals of the cache refill controller.
interface cache_refill_if;
    import cache_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_ready, cpu_rdata, cpu_hit, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_ready, cpu_rdata, cpu_hit, busy, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_tag_array.sv
// 8-entry line store: combinational read by index, synchronous write,
// synchronous active-low clear of all valid bits.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] rd_idx_i,
    output line_t               rd_line_o,
    input  logic                wr_en_i,
    input  logic [SET_BITS-1:0] wr_idx_i,
    input  line_t               wr_line_i
);
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [DATA_W-1:0]   data_q [NUM_SETS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_line_i.v;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_line_i.tag;
            data_q[wr_idx_i] <= wr_line_i.data;
        end
    end

    assign rd_line_o = '{v: valid_q[rd_idx_i], tag: tag_q[rd_idx_i], data: data_q[rd_idx_i]};
endmodule

// File: rtl/cache_refill.sv
// Direct-mapped cache controller: serves load hits from the array, refills on a load miss,
// and writes stores through to memory without allocating.
module cache_refill
    import cache_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_if.slave        bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q;
    logic                 cpu_ready_q;
    logic                 cpu_hit_q;
    logic [DATA_W-1:0]    cpu_rdata_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 st_hit_q;
    logic [CNT_WIDTH-1:0] hit_cnt_q;
    logic [CNT_WIDTH-1:0] miss_cnt_q;

    waddr_t req_f;
    waddr_t fill_f;
    line_t  rd_line;
    logic   lookup_hit;
    logic   arr_we;
    line_t  arr_wline;

    assign req_f      = split_addr(bus.cpu_addr[ADDR_W-1:2]);
    assign fill_f     = split_addr(mem_addr_q[ADDR_W-1:2]);
    assign lookup_hit = rd_line.v && (rd_line.tag == req_f.tag);

    // A store hit rewrites only data; tag and valid written back equal what the hit matched.
    always_comb begin
        arr_we    = 1'b0;
        arr_wline = '{v: 1'b1, tag: fill_f.tag, data: bus.mem_rdata};
        if (state_q == MEM_RD && bus.mem_ack) begin
            arr_we = 1'b1;
        end else if (state_q == MEM_WR && bus.mem_ack && st_hit_q) begin
            arr_we         = 1'b1;
            arr_wline.data = mem_wdata_q;
        end
    end

    cache_tag_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (req_f.idx),
        .rd_line_o (rd_line),
        .wr_en_i   (arr_we),
        .wr_idx_i  (fill_f.idx),
        .wr_line_i (arr_wline)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            st_hit_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        mem_addr_q <= bus.cpu_addr & ~ADDR_W'(3);
                        if (bus.cpu_we) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.cpu_wdata;
                            st_hit_q    <= lookup_hit;
                            state_q     <= MEM_WR;
                        end else if (lookup_hit) begin
                            cpu_ready_q <= 1'b1;
                            cpu_hit_q   <= 1'b1;
                            cpu_rdata_q <= rd_line.data;
                            if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
                            state_q     <= RESP;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
                            state_q   <= MEM_RD;
                        end
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_hit_q   <= 1'b0;
                        cpu_rdata_q <= bus.mem_rdata;
                        state_q     <= RESP;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_hit_q   <= st_hit_q;
                        state_q     <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_hit   = cpu_hit_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_cache_refill.sv
// Self-checking bench for cache_refill: a cache/counter model plus a per-cycle expected
// timeline, compared against the DUT one time unit after every rising edge.
module tb_cache_refill;
    import cache_pkg::*;

    // Counters are narrowed so saturation is reachable in a short run.
    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    cache_refill_if bus ();

    cache_refill #(.CNT_WIDTH(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit               m_v    [8];
    logic [26:0]      m_tag  [8];
    logic [31:0]      m_data [8];
    logic [CNT_W-1:0] c_hits;
    logic [CNT_W-1:0] c_miss;

    bit          e_on, e_rst, e_busy, e_req, e_we, e_ready, e_hit, e_rdchk;
    logic [31:0] e_addr, e_wdata, e_rdata;

    int          req_cycles;
    logic [31:0] last_rdata;
    logic        last_hit;
    logic [31:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (e_on) begin
            if (e_rst) begin
                chk("rst_cpu_ready", bus.cpu_ready, 0);
                chk("rst_cpu_rdata", bus.cpu_rdata, 0);
                chk("rst_cpu_hit", bus.cpu_hit, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_mem_req", bus.mem_req, 0);
                chk("rst_mem_we", bus.mem_we, 0);
                chk("rst_mem_addr", bus.mem_addr, 0);
                chk("rst_mem_wdata", bus.mem_wdata, 0);
                chk("rst_hit_count", hit_count, 0);
                chk("rst_miss_count", miss_count, 0);
            end else begin
                chk("busy", bus.busy, e_busy);
                chk("mem_req", bus.mem_req, e_req);
                chk("cpu_ready", bus.cpu_ready, e_ready);
                chk("hit_count", hit_count, c_hits);
                chk("miss_count", miss_count, c_miss);
                if (e_req) begin
                    chk("mem_we", bus.mem_we, e_we);
                    chk("mem_addr", bus.mem_addr, e_addr);
                    if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
                end
                if (e_ready) begin
                    chk("cpu_hit", bus.cpu_hit, e_hit);
                    if (e_rdchk) chk("cpu_rdata", bus.cpu_rdata, e_rdata);
                end
            end
        end
        if (bus.mem_req === 1'b1) req_cycles++;
        if (bus.cpu_ready === 1'b1) begin
            last_rdata = bus.cpu_rdata;
            last_hit   = bus.cpu_hit;
        end
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) last_wdata = bus.mem_wdata;
    end

    task automatic exp_idle();
        e_rst = 0; e_busy = 0; e_req = 0; e_ready = 0;
    endtask

    task automatic exp_mem(input bit we, input logic [31:0] a, input logic [31:0] wd);
        e_rst = 0; e_busy = 1; e_req = 1; e_ready = 0;
        e_we = we; e_addr = a & ~32'h3; e_wdata = wd;
    endtask

    task automatic exp_resp(input bit h, input bit rchk, input logic [31:0] rd);
        e_rst = 0; e_busy = 1; e_req = 0; e_ready = 1;
        e_hit = h; e_rdchk = rchk; e_rdata = rd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        bus.mem_ack = 1'b0;
        foreach (m_v[i]) m_v[i] = 1'b0;
        c_hits = '0;
        c_miss = '0;
        e_rst = 1;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        exp_idle();
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    // One CPU request from acceptance through RESP and the following IDLE cycle.
    // abort > 0 resets the DUT after that many memory cycles instead of acknowledging.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input int abort);
        int          idx;
        logic [26:0] tg;
        bit          hit;
        idx = int'(addr[4:2]);
        tg  = addr[31:5];
        hit = m_v[idx] && (m_tag[idx] == tg);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        req_cycles    = 0;
        if (!we && hit) begin
            if (c_hits != CNT_MAX) c_hits++;
            exp_resp(1, 1, m_data[idx]);
            @(negedge clk);
        end else begin
            if (!we && c_miss != CNT_MAX) c_miss++;
            exp_mem(we, addr, wd);
            @(negedge clk);
            if (abort > 0) begin
                bus.mem_ack = 1'b0;
                for (int c = 1; c < abort; c++) @(negedge clk);
                do_reset(2);
                return;
            end
            for (int c = 1; c < dly; c++) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                @(negedge clk);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            if (!we) begin
                m_v[idx]    = 1'b1;
                m_tag[idx]  = tg;
                m_data[idx] = rd;
            end else if (hit) begin
                m_data[idx] = wd;
            end
            exp_resp(we ? hit : 1'b0, !we, rd);
            @(negedge clk);
        end
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = $urandom;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        exp_idle();
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        e_busy = 0; e_req = 0; e_we = 0; e_ready = 0; e_hit = 0; e_rdchk = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        req_cycles = 0; last_rdata = '0; last_hit = 1'b0; last_wdata = '0;
        e_on = 1;
        do_reset(2);

        txn(0, 32'h0000_0010, 0, 3, 32'hDEAD_BEEF, 0);
        chk("lit_fill_req_cycles", req_cycles, 3);
        chk("lit_fill_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("lit_fill_hit", last_hit, 0);
        chk("lit_fill_miss_count", miss_count, 1);

        txn(0, 32'h0000_0010, 0, 1, 32'h0, 0);
        chk("lit_hit_req_cycles", req_cycles, 0);
        chk("lit_hit_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("lit_hit_flag", last_hit, 1);
        chk("lit_hit_count", hit_count, 1);

        txn(0, 32'h0000_0030, 0, 2, 32'hCAFE_0030, 0);
        chk("lit_conflict_hit", last_hit, 0);
        txn(0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 0);
        chk("lit_evicted_hit", last_hit, 0);
        chk("lit_evicted_miss_count", miss_count, 3);

        txn(0, 32'h0000_0030, 0, 1, 32'hCAFE_0030, 0);
        txn(1, 32'h0000_0030, 32'h1234_5678, 2, 32'h0, 0);
        chk("lit_store_hit", last_hit, 1);
        chk("lit_store_wdata", last_wdata, 32'h1234_5678);
        txn(0, 32'h0000_0030, 0, 1, 32'h0, 0);
        chk("lit_store_readback", last_rdata, 32'h1234_5678);
        chk("lit_store_readback_hit", last_hit, 1);

        txn(1, 32'h0000_0050, 32'hAAAA_5555, 1, 32'h0, 0);
        chk("lit_store_miss_hit", last_hit, 0);
        txn(0, 32'h0000_0030, 0, 1, 32'h0, 0);
        chk("lit_set_unchanged", last_rdata, 32'h1234_5678);

        txn(0, 32'h0000_0064, 0, 1, 32'h0, 2);
        chk("lit_rst_miss_count", miss_count, 0);
        txn(0, 32'h0000_0064, 0, 2, 32'h0BAD_F00D, 0);
        chk("lit_after_rst_hit", last_hit, 0);
        chk("lit_after_rst_miss_count", miss_count, 1);

        txn(0, 32'h0000_0030, 0, 1, 32'h5A5A_5A5A, 0);
        chk("lit_after_rst_line_gone", last_hit, 0);
        repeat (int'(CNT_MAX) + 2) txn(0, 32'h0000_0030, 0, 1, 32'h0, 0);
        chk("lit_hit_saturate", hit_count, CNT_MAX);
        chk("lit_sat_rdata", last_rdata, 32'h5A5A_5A5A);

        repeat (600) begin
            txn($urandom_range(0, 3) == 0, rand_addr(), $urandom, $urandom_range(1, 4), $urandom,
                ($urandom_range(0, 59) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
